// File: rtl/mor1kx_wb_ibus_dbus_arbiter_if.sv
// ---------------------------------------------------------------------------
// mor1kx_wb_ibus_dbus_arbiter_if
//
// One Wishbone B3 link (request + response bundle) as used by the
// ibus/dbus arbiter.
//
//   adr   [31:0]  address                 (master -> slave)
//   wdat  [31:0]  write data              (master -> slave)
//   stb           strobe                  (master -> slave)
//   cyc           cycle                   (master -> slave)
//   we            write enable            (master -> slave)
//   sel   [3:0]   byte select             (master -> slave)
//   cti   [2:0]   cycle type identifier   (master -> slave)
//   bte   [1:0]   burst type extension    (master -> slave)
//   ack/err/rty   responses               (slave -> master)
//   rdat  [31:0]  read data               (slave -> master)
//
// modport master : the side that issues requests
// modport slave  : the side that answers requests
// ---------------------------------------------------------------------------
interface mor1kx_wb_ibus_dbus_arbiter_if;
  logic [31:0] adr;
  logic [31:0] wdat;
  logic        stb;
  logic        cyc;
  logic        we;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack;
  logic        err;
  logic        rty;
  logic [31:0] rdat;

  modport master (
    output adr, wdat, stb, cyc, we, sel, cti, bte,
    input  ack, err, rty, rdat
  );

  modport slave (
    input  adr, wdat, stb, cyc, we, sel, cti, bte,
    output ack, err, rty, rdat
  );
endinterface

// File: rtl/mor1kx_wb_ibus_dbus_arbiter.sv
// ---------------------------------------------------------------------------
// mor1kx_wb_ibus_dbus_arbiter
//
// Two-master Wishbone B3 arbiter: merges the instruction-bus bridge (iwbs)
// and the data-bus bridge (dwbs) onto a single master port (wbm). Ownership
// is held for an entire cyc, bursts included, and only changes by passing
// through IDLE. A watchdog aborts transfers whose slave never answers.
//
// Parameters
//   ARB_POLICY      "ROUND_ROBIN" | "DBUS_FIRST" : tie-break on simultaneous requests
//   TIMEOUT_CYCLES  stb cycles without response before abort; 0 disables
//   TIMEOUT_WIDTH   watchdog counter width, must hold TIMEOUT_CYCLES
//
// Ports
//   clk   clock
//   rst   synchronous reset, active high
//   iwbs  ibus bridge link (slave modport: arbiter answers the bridge)
//   dwbs  dbus bridge link (slave modport)
//   wbm   merged link toward the interconnect (master modport)
// ---------------------------------------------------------------------------
module mor1kx_wb_ibus_dbus_arbiter #(
  parameter string       ARB_POLICY     = "ROUND_ROBIN",
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TIMEOUT_WIDTH  = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  mor1kx_wb_ibus_dbus_arbiter_if.slave          iwbs,
  mor1kx_wb_ibus_dbus_arbiter_if.slave          dwbs,
  mor1kx_wb_ibus_dbus_arbiter_if.master         wbm
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_IGNT,
    ST_DGNT,
    ST_ABORT
  } state_t;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  localparam bit LP_DBUS_FIRST = (ARB_POLICY == "DBUS_FIRST");
  localparam bit LP_WDOG_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [TIMEOUT_WIDTH-1:0] LP_WDOG_LAST =
    TIMEOUT_WIDTH'((TIMEOUT_CYCLES == 0) ? 32'd0 : TIMEOUT_CYCLES - 32'd1);

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic                     r_owner;
  logic                     w_owner_nxt;
  logic                     r_last_owner;
  logic                     w_last_owner_nxt;
  logic [TIMEOUT_WIDTH-1:0] r_wdog;

  logic                     w_granted;
  logic                     w_resp;
  logic                     w_timeout;

  logic [31:0]              w_own_adr;
  logic [31:0]              w_own_wdat;
  logic                     w_own_stb;
  logic                     w_own_cyc;
  logic                     w_own_we;
  logic [3:0]               w_own_sel;
  logic [2:0]               w_own_cti;
  logic [1:0]               w_own_bte;

  // Request bundle of whichever bridge currently owns (or last owned) the bus.
  // r_owner stays valid through ABORT so the release can be tracked there.
  assign w_own_adr  = (r_owner == OWNER_D) ? dwbs.adr  : iwbs.adr;
  assign w_own_wdat = (r_owner == OWNER_D) ? dwbs.wdat : iwbs.wdat;
  assign w_own_stb  = (r_owner == OWNER_D) ? dwbs.stb  : iwbs.stb;
  assign w_own_cyc  = (r_owner == OWNER_D) ? dwbs.cyc  : iwbs.cyc;
  assign w_own_we   = (r_owner == OWNER_D) ? dwbs.we   : iwbs.we;
  assign w_own_sel  = (r_owner == OWNER_D) ? dwbs.sel  : iwbs.sel;
  assign w_own_cti  = (r_owner == OWNER_D) ? dwbs.cti  : iwbs.cti;
  assign w_own_bte  = (r_owner == OWNER_D) ? dwbs.bte  : iwbs.bte;

  // rst gates the grant so every output is already quiet while reset is held.
  assign w_granted = ((r_state == ST_IGNT) || (r_state == ST_DGNT)) && !rst;
  assign w_resp    = wbm.ack | wbm.err | wbm.rty;

  // A slave response in the last allowed cycle wins over the abort.
  assign w_timeout = LP_WDOG_EN && w_granted && w_own_stb && !w_resp &&
                     (r_wdog == LP_WDOG_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_owner      <= OWNER_I;
      r_last_owner <= OWNER_D;
      r_wdog       <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_last_owner <= w_last_owner_nxt;
      if (!LP_WDOG_EN || !w_granted || !w_own_stb || w_resp) begin
        r_wdog <= '0;
      end else begin
        r_wdog <= r_wdog + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_owner_nxt      = r_owner;
    w_last_owner_nxt = r_last_owner;

    wbm.adr  = '0;
    wbm.wdat = '0;
    wbm.stb  = 1'b0;
    wbm.cyc  = 1'b0;
    wbm.we   = 1'b0;
    wbm.sel  = '0;
    wbm.cti  = '0;
    wbm.bte  = '0;

    iwbs.ack  = 1'b0;
    iwbs.err  = 1'b0;
    iwbs.rty  = 1'b0;
    iwbs.rdat = '0;
    dwbs.ack  = 1'b0;
    dwbs.err  = 1'b0;
    dwbs.rty  = 1'b0;
    dwbs.rdat = '0;

    if (w_granted) begin
      wbm.adr  = w_own_adr;
      wbm.wdat = w_own_wdat;
      wbm.stb  = w_own_stb;
      wbm.cyc  = w_own_cyc;
      wbm.we   = w_own_we;
      wbm.sel  = w_own_sel;
      wbm.cti  = w_own_cti;
      wbm.bte  = w_own_bte;

      iwbs.rdat = wbm.rdat;
      dwbs.rdat = wbm.rdat;

      if (r_owner == OWNER_D) begin
        dwbs.ack = wbm.ack;
        dwbs.err = wbm.err | w_timeout;
        dwbs.rty = wbm.rty;
      end else begin
        iwbs.ack = wbm.ack;
        iwbs.err = wbm.err | w_timeout;
        iwbs.rty = wbm.rty;
      end
    end

    unique case (r_state)
      ST_IDLE: begin
        if (iwbs.cyc && dwbs.cyc) begin
          if (LP_DBUS_FIRST || (r_last_owner == OWNER_I)) begin
            w_state_nxt = ST_DGNT;
            w_owner_nxt = OWNER_D;
          end else begin
            w_state_nxt = ST_IGNT;
            w_owner_nxt = OWNER_I;
          end
        end else if (iwbs.cyc) begin
          w_state_nxt = ST_IGNT;
          w_owner_nxt = OWNER_I;
        end else if (dwbs.cyc) begin
          w_state_nxt = ST_DGNT;
          w_owner_nxt = OWNER_D;
        end
      end
      ST_IGNT, ST_DGNT: begin
        if (!w_own_cyc) begin
          w_state_nxt      = ST_IDLE;
          w_last_owner_nxt = r_owner;
        end else if (w_timeout) begin
          w_state_nxt = ST_ABORT;
        end
      end
      ST_ABORT: begin
        if (!w_own_cyc) begin
          w_state_nxt      = ST_IDLE;
          w_last_owner_nxt = r_owner;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mor1kx_wb_ibus_dbus_arbiter.sv
// Bench for mor1kx_wb_ibus_dbus_arbiter.
// u_rr: ROUND_ROBIN, TIMEOUT_CYCLES=4. u_df: DBUS_FIRST, default watchdog.
module tb_mor1kx_wb_ibus_dbus_arbiter;

  localparam logic [31:0] IADR = 32'h0000_0100;
  localparam logic [31:0] DADR = 32'h0000_1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mor1kx_wb_ibus_dbus_arbiter_if ifa_i ();
  mor1kx_wb_ibus_dbus_arbiter_if ifa_d ();
  mor1kx_wb_ibus_dbus_arbiter_if ifa_m ();
  mor1kx_wb_ibus_dbus_arbiter_if ifb_i ();
  mor1kx_wb_ibus_dbus_arbiter_if ifb_d ();
  mor1kx_wb_ibus_dbus_arbiter_if ifb_m ();

  mor1kx_wb_ibus_dbus_arbiter #(
    .ARB_POLICY    ("ROUND_ROBIN"),
    .TIMEOUT_CYCLES(4),
    .TIMEOUT_WIDTH (8)
  ) u_rr (
    .clk (clk),
    .rst (rst),
    .iwbs(ifa_i),
    .dwbs(ifa_d),
    .wbm (ifa_m)
  );

  mor1kx_wb_ibus_dbus_arbiter #(
    .ARB_POLICY    ("DBUS_FIRST"),
    .TIMEOUT_CYCLES(255),
    .TIMEOUT_WIDTH (8)
  ) u_df (
    .clk (clk),
    .rst (rst),
    .iwbs(ifb_i),
    .dwbs(ifb_d),
    .wbm (ifb_m)
  );

  int n_total = 0;
  int n_bad   = 0;

  typedef struct {
    logic        rst;
    logic        ireq;
    logic        dreq;
    logic        ack;
    logic        err;
    logic [31:0] sdat;
    logic        e_cyc;
    logic [31:0] e_adr;
    logic        e_iack;
    logic        e_ierr;
    logic        e_dack;
    logic        e_derr;
    logic [31:0] e_dat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic ir, input logic dr,
                              input logic ak, input logic er, input logic [31:0] sd,
                              input logic ec, input logic [31:0] ea,
                              input logic eia, input logic eie,
                              input logic eda, input logic ede,
                              input logic [31:0] edat);
    vec_t v;
    v.rst = r; v.ireq = ir; v.dreq = dr; v.ack = ak; v.err = er; v.sdat = sd;
    v.e_cyc = ec; v.e_adr = ea; v.e_iack = eia; v.e_ierr = eie;
    v.e_dack = eda; v.e_derr = ede; v.e_dat = edat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic drv_a(input logic r, input logic ir, input logic dr,
                       input logic ak, input logic er, input logic [31:0] sd);
    rst        = r;
    ifa_i.cyc  = ir;
    ifa_i.stb  = ir;
    ifa_i.adr  = ir ? IADR : 32'h0;
    ifa_i.cti  = 3'b000;
    ifa_i.bte  = 2'b00;
    ifa_d.cyc  = dr;
    ifa_d.stb  = dr;
    ifa_d.adr  = dr ? DADR : 32'h0;
    ifa_d.cti  = 3'b000;
    ifa_d.bte  = 2'b00;
    ifa_m.ack  = ak;
    ifa_m.err  = er;
    ifa_m.rty  = 1'b0;
    ifa_m.rdat = sd;
  endtask

  task automatic drv_b(input logic ir, input logic dr);
    ifb_i.cyc = ir;
    ifb_i.stb = ir;
    ifb_i.adr = ir ? IADR : 32'h0;
    ifb_d.cyc = dr;
    ifb_d.stb = dr;
    ifb_d.adr = dr ? DADR : 32'h0;
  endtask

  task automatic init_link(output logic [31:0] adr, output logic [31:0] wdat,
                           output logic stb, output logic cyc, output logic we,
                           output logic [3:0] sel, output logic [2:0] cti,
                           output logic [1:0] bte);
    adr = '0; wdat = '0; stb = 1'b0; cyc = 1'b0; we = 1'b0;
    sel = 4'hF; cti = '0; bte = '0;
  endtask

  initial begin
    init_link(ifa_i.adr, ifa_i.wdat, ifa_i.stb, ifa_i.cyc, ifa_i.we, ifa_i.sel, ifa_i.cti, ifa_i.bte);
    init_link(ifa_d.adr, ifa_d.wdat, ifa_d.stb, ifa_d.cyc, ifa_d.we, ifa_d.sel, ifa_d.cti, ifa_d.bte);
    init_link(ifb_i.adr, ifb_i.wdat, ifb_i.stb, ifb_i.cyc, ifb_i.we, ifb_i.sel, ifb_i.cti, ifb_i.bte);
    init_link(ifb_d.adr, ifb_d.wdat, ifb_d.stb, ifb_d.cyc, ifb_d.we, ifb_d.sel, ifb_d.cti, ifb_d.bte);
    ifa_m.ack = 1'b0; ifa_m.err = 1'b0; ifa_m.rty = 1'b0; ifa_m.rdat = '0;
    ifb_m.ack = 1'b0; ifb_m.err = 1'b0; ifb_m.rty = 1'b0; ifb_m.rdat = '0;

    //            rst i d ack err sdat            cyc adr  ia ie da de dat
    vecs.push_back(mk(1,1,1,0,0,32'h0,            0,32'h0,0,0,0,0,32'h0));  // reset held
    vecs.push_back(mk(1,1,1,0,0,32'h0,            0,32'h0,0,0,0,0,32'h0));
    vecs.push_back(mk(1,1,1,0,0,32'h0,            0,32'h0,0,0,0,0,32'h0));
    vecs.push_back(mk(0,1,1,0,0,32'h0,            0,32'h0,0,0,0,0,32'h0));  // first cycle after rst
    vecs.push_back(mk(0,1,1,0,0,32'h0,            1,IADR, 0,0,0,0,32'h0));  // ibus wins (last=D)
    vecs.push_back(mk(0,1,1,1,0,32'h1111_1111,    1,IADR, 1,0,0,0,32'h1111_1111));
    vecs.push_back(mk(0,0,1,0,0,32'h0,            0,32'h0,0,0,0,0,32'h0));  // ibus releases
    vecs.push_back(mk(0,1,1,0,0,32'h0,            0,32'h0,0,0,0,0,32'h0));  // idle, tie -> dbus
    vecs.push_back(mk(0,1,1,0,0,32'h0,            1,DADR, 0,0,0,0,32'h0));
    vecs.push_back(mk(0,1,1,0,0,32'h0,            1,DADR, 0,0,0,0,32'h0));
    vecs.push_back(mk(0,1,1,1,0,32'hDEAD_BEEF,    1,DADR, 0,0,1,0,32'hDEAD_BEEF));
    vecs.push_back(mk(0,1,0,0,0,32'h0,            0,32'h0,0,0,0,0,32'h0));  // dbus releases
    vecs.push_back(mk(0,1,0,0,0,32'h0,            0,32'h0,0,0,0,0,32'h0));  // idle
    vecs.push_back(mk(0,1,0,0,0,32'h0,            1,IADR, 0,0,0,0,32'h0));  // stb 1
    vecs.push_back(mk(0,1,0,0,0,32'h0,            1,IADR, 0,0,0,0,32'h0));  // stb 2
    vecs.push_back(mk(0,1,0,0,0,32'h0,            1,IADR, 0,0,0,0,32'h0));  // stb 3
    vecs.push_back(mk(0,1,0,0,0,32'h0,            1,IADR, 0,1,0,0,32'h0));  // stb 4: timeout err
    vecs.push_back(mk(0,1,0,1,0,32'h0,            0,32'h0,0,0,0,0,32'h0));  // abort, late ack dropped
    vecs.push_back(mk(0,1,0,0,0,32'h0,            0,32'h0,0,0,0,0,32'h0));
    vecs.push_back(mk(0,0,0,0,0,32'h0,            0,32'h0,0,0,0,0,32'h0));  // ibus drops in abort
    vecs.push_back(mk(0,0,0,0,0,32'h0,            0,32'h0,0,0,0,0,32'h0));
    vecs.push_back(mk(0,1,1,0,0,32'h0,            0,32'h0,0,0,0,0,32'h0));  // tie, last=I -> dbus
    vecs.push_back(mk(0,1,1,0,0,32'h0,            1,DADR, 0,0,0,0,32'h0));
    vecs.push_back(mk(0,1,0,0,0,32'h0,            0,32'h0,0,0,0,0,32'h0));
    vecs.push_back(mk(0,1,0,0,0,32'h0,            0,32'h0,0,0,0,0,32'h0));
    vecs.push_back(mk(0,1,0,0,0,32'h0,            1,IADR, 0,0,0,0,32'h0));  // stb 1
    vecs.push_back(mk(0,1,0,0,0,32'h0,            1,IADR, 0,0,0,0,32'h0));  // stb 2
    vecs.push_back(mk(0,1,0,0,0,32'h0,            1,IADR, 0,0,0,0,32'h0));  // stb 3
    vecs.push_back(mk(0,1,0,1,0,32'hA5A5_A5A5,    1,IADR, 1,0,0,0,32'hA5A5_A5A5)); // ack beats timeout
    vecs.push_back(mk(0,1,0,0,1,32'h0,            1,IADR, 0,1,0,0,32'h0));  // slave err forwarded
    vecs.push_back(mk(0,1,0,0,0,32'h0,            1,IADR, 0,0,0,0,32'h0));  // still granted
    vecs.push_back(mk(0,0,0,0,0,32'h0,            0,32'h0,0,0,0,0,32'h0));

    for (int i = 0; i < vecs.size(); i++) begin
      step();
      drv_a(vecs[i].rst, vecs[i].ireq, vecs[i].dreq, vecs[i].ack, vecs[i].err, vecs[i].sdat);
      samp();
      chk($sformatf("v%0d.cyc", i),  {31'b0, ifa_m.cyc},  {31'b0, vecs[i].e_cyc});
      chk($sformatf("v%0d.stb", i),  {31'b0, ifa_m.stb},  {31'b0, vecs[i].e_cyc});
      if (vecs[i].e_cyc) chk($sformatf("v%0d.adr", i), ifa_m.adr, vecs[i].e_adr);
      chk($sformatf("v%0d.iack", i), {31'b0, ifa_i.ack},  {31'b0, vecs[i].e_iack});
      chk($sformatf("v%0d.ierr", i), {31'b0, ifa_i.err},  {31'b0, vecs[i].e_ierr});
      chk($sformatf("v%0d.dack", i), {31'b0, ifa_d.ack},  {31'b0, vecs[i].e_dack});
      chk($sformatf("v%0d.derr", i), {31'b0, ifa_d.err},  {31'b0, vecs[i].e_derr});
      chk($sformatf("v%0d.idat", i), ifa_i.rdat, vecs[i].e_dat);
      chk($sformatf("v%0d.ddat", i), ifa_d.rdat, vecs[i].e_dat);
    end

    // 8-beat ibus incrementing burst from reset, dbus also requesting.
    step(); drv_a(1, 1, 1, 0, 0, 32'h0);
    samp();
    step(); drv_a(0, 1, 1, 0, 0, 32'h0);
    samp(); chk("burst.idle", {31'b0, ifa_m.cyc}, 32'h0);
    for (int k = 0; k < 8; k++) begin
      step();
      drv_a(0, 1, 1, 1, 0, 32'hB000_0000 + k);
      ifa_i.adr = 32'h2000 + 32'(k * 4);
      ifa_i.cti = (k == 7) ? 3'b111 : 3'b010;
      ifa_i.bte = 2'b00;
      samp();
      chk($sformatf("burst%0d.cyc", k),  {31'b0, ifa_m.cyc}, 32'h1);
      chk($sformatf("burst%0d.adr", k),  ifa_m.adr, 32'h2000 + 32'(k * 4));
      chk($sformatf("burst%0d.cti", k),  {29'b0, ifa_m.cti}, (k == 7) ? 32'h7 : 32'h2);
      chk($sformatf("burst%0d.bte", k),  {30'b0, ifa_m.bte}, 32'h0);
      chk($sformatf("burst%0d.iack", k), {31'b0, ifa_i.ack}, 32'h1);
      chk($sformatf("burst%0d.dack", k), {31'b0, ifa_d.ack}, 32'h0);
      chk($sformatf("burst%0d.idat", k), ifa_i.rdat, 32'hB000_0000 + k);
    end
    step(); drv_a(0, 0, 1, 0, 0, 32'h0);
    samp(); chk("handover.rel", {31'b0, ifa_m.cyc}, 32'h0);
    step();
    samp(); chk("handover.idle", {31'b0, ifa_m.cyc}, 32'h0);

    // dbus burst, reset asserted on beat 3.
    for (int k = 0; k < 4; k++) begin
      step();
      drv_a((k == 3) ? 1'b1 : 1'b0, 1, 1, 1, 0, 32'hC000_0000 + k);
      ifa_d.adr = DADR + 32'(k * 4);
      ifa_d.cti = 3'b010;
      samp();
      if (k < 3) begin
        chk($sformatf("dburst%0d.cyc", k),  {31'b0, ifa_m.cyc}, 32'h1);
        chk($sformatf("dburst%0d.adr", k),  ifa_m.adr, DADR + 32'(k * 4));
        chk($sformatf("dburst%0d.dack", k), {31'b0, ifa_d.ack}, 32'h1);
        chk($sformatf("dburst%0d.iack", k), {31'b0, ifa_i.ack}, 32'h0);
      end
    end
    step(); drv_a(0, 1, 1, 0, 0, 32'h0);
    samp(); chk("midrst.cyc", {31'b0, ifa_m.cyc}, 32'h0);
    step();
    samp();
    chk("midrst.regrant.cyc", {31'b0, ifa_m.cyc}, 32'h1);
    chk("midrst.regrant.adr", ifa_m.adr, IADR);
    step(); drv_a(0, 0, 0, 0, 0, 32'h0);

    // DBUS_FIRST: dbus wins every tie; ibus only when dcyc is low in IDLE.
    for (int r = 0; r < 3; r++) begin
      step(); drv_b(1, 1);
      samp(); chk($sformatf("df%0d.idle", r), {31'b0, ifb_m.cyc}, 32'h0);
      step();
      samp();
      chk($sformatf("df%0d.cyc", r), {31'b0, ifb_m.cyc}, 32'h1);
      chk($sformatf("df%0d.adr", r), ifb_m.adr, DADR);
      step(); drv_b(1, 0);
      samp(); chk($sformatf("df%0d.rel", r), {31'b0, ifb_m.cyc}, 32'h0);
    end
    step();
    samp(); chk("df.ionly.idle", {31'b0, ifb_m.cyc}, 32'h0);
    step();
    samp();
    chk("df.ionly.cyc", {31'b0, ifb_m.cyc}, 32'h1);
    chk("df.ionly.adr", ifb_m.adr, IADR);
    step(); drv_b(0, 0);
    samp();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
